ysyx_23060184_axi_rd_arbiter: RTL and testbench

Two-requester AXI4-Lite read arbiter sharing one read master port (io_master_ar*/r*) between the IFU and the LSU. It arbitrates between them, then routes full AR and R channel handshakes to the granted requester. It holds ownership from address issue until the read response completes. It sits between the core's fetch/load units and the SoC/memory interconnect.

---
 rtl/ysyx_23060184_pkg.sv | 23 ++
 rtl/ysyx_23060184_arb_pick.sv | 46 ++++
 rtl/ysyx_23060184_axi_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_ysyx_23060184_axi_rd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_pkg.sv
// Shared definitions for the AXI4-Lite read arbiter.
//   arb_state_e : arbiter FSM encodings (2'b11 is illegal and is steered back to idle)
//   arb_owner_e : which requester currently owns the read master port
//   AXI_RESP_*  : AXI read response codes; the arbiter forwards these without decoding them
package ysyx_23060184_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060184_arb_pick.sv
// Combinational winner selection for the IFU/LSU read arbiter.
// Ports:
//   ifu_req    in  IFU has a read request pending
//   lsu_req    in  LSU has a read request pending
//   last_owner in  requester that completed the most recent transaction
//   winner     out requester to grant (only meaningful when a request is pending)
// Configuration:
//   YSYX_23060184_ARB_RR_EN defined   : round-robin, a tie goes to the requester that is not
//                                       last_owner
//   YSYX_23060184_ARB_RR_EN undefined : fixed priority, LSU wins a tie
module ysyx_23060184_arb_pick
    import ysyx_23060184_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
    input  arb_owner_e last_owner,
    output arb_owner_e winner
);

`ifdef YSYX_23060184_ARB_RR_EN
    always_comb begin
        if (ifu_req && lsu_req) begin
            winner = (last_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (lsu_req) begin
            winner = OWN_LSU;
        end else begin
            winner = OWN_IFU;
        end
    end
`else
    // History is not needed for fixed priority.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = OWN_IFU;
        if (lsu_req) begin
            winner = OWN_LSU;
        end
        if (!ifu_req && !lsu_req) begin
            winner = OWN_IFU;
        end
    end
`endif

endmodule

// File: rtl/ysyx_23060184_axi_rd_arbiter.sv
// Two-requester AXI4-Lite read arbiter: shares one read master port between the IFU and LSU.
// Ownership is taken in IDLE, held through the AR handshake (ADDR) and the R handshake (RESP).
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   ifu_ar*/ifu_r*                 IFU read request / response channel
//   lsu_ar*/lsu_r*                 LSU read request / response channel
//   io_master_ar*/io_master_r*     shared downstream read master port
// Configuration:
//   YSYX_23060184_ARB_RR_EN        selects round-robin instead of fixed LSU priority
module ysyx_23060184_axi_rd_arbiter
    import ysyx_23060184_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,

    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_WIDTH-1:0] lsu_araddr,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,

    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_WIDTH-1:0] io_master_araddr,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_WIDTH-1:0] io_master_rdata,
    input  logic [1:0]            io_master_rresp
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e last_owner_q, last_owner_d;
    arb_owner_e winner;

    logic                  own_arvalid;
    logic [ADDR_WIDTH-1:0] own_araddr;
    logic                  own_rready;

    ysyx_23060184_arb_pick u_pick (
        .ifu_req    (ifu_arvalid),
        .lsu_req    (lsu_arvalid),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    // Request-side signals of whichever requester currently owns the port.
    always_comb begin
        own_arvalid = (owner_q == OWN_LSU) ? lsu_arvalid : ifu_arvalid;
        own_araddr  = (owner_q == OWN_LSU) ? lsu_araddr  : ifu_araddr;
        own_rready  = (owner_q == OWN_LSU) ? lsu_rready  : ifu_rready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_IFU;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    owner_d = winner;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // An owner that withdraws its request releases the port without issuing anything.
                if (!own_arvalid) begin
                    state_d = ARB_IDLE;
                end else if (io_master_arready) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (io_master_rvalid && own_rready) begin
                    last_owner_d = owner_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output routing. Outputs are forced low while reset is asserted so a response in flight
    // is never presented to a requester during reset.
    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_rready  = 1'b0;
        ifu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        ifu_rdata         = '0;
        ifu_rresp         = '0;
        lsu_arready       = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_rdata         = '0;
        lsu_rresp         = '0;
        if (rstn) begin
            case (state_q)
                ARB_ADDR: begin
                    io_master_arvalid = own_arvalid;
                    io_master_araddr  = own_araddr;
                    if (owner_q == OWN_LSU) begin
                        lsu_arready = io_master_arready;
                    end else begin
                        ifu_arready = io_master_arready;
                    end
                end
                ARB_RESP: begin
                    io_master_rready = own_rready;
                    if (owner_q == OWN_LSU) begin
                        lsu_rvalid = io_master_rvalid;
                        lsu_rdata  = io_master_rdata;
                        lsu_rresp  = io_master_rresp;
                    end else begin
                        ifu_rvalid = io_master_rvalid;
                        ifu_rdata  = io_master_rdata;
                        ifu_rresp  = io_master_rresp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axi_rd_arbiter.sv
module tb_ysyx_23060184_axi_rd_arbiter;

`ifdef YSYX_23060184_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] ZA = 32'h0;
    localparam logic [1:0]  R0 = 2'b00;
    localparam logic [1:0]  R1 = 2'b01;
    localparam logic [1:0]  R2 = 2'b10;

    localparam logic [31:0] A0    = 32'h8000_0000;
    localparam logic [31:0] A4    = 32'h8000_0004;
    localparam logic [31:0] A8    = 32'h8000_0008;
    localparam logic [31:0] A1000 = 32'h8000_1000;
    localparam logic [31:0] A2000 = 32'h8000_2000;
    localparam logic [31:0] A3000 = 32'h8000_3000;

    typedef struct packed {
        logic        rstn;
        logic        i_arvalid;
        logic [31:0] i_araddr;
        logic        i_rready;
        logic        l_arvalid;
        logic [31:0] l_araddr;
        logic        l_rready;
        logic        m_arready;
        logic        m_rvalid;
        logic [31:0] m_rdata;
        logic [1:0]  m_rresp;
    } in_t;

    typedef struct packed {
        logic        m_arvalid;
        logic [31:0] m_araddr;
        logic        m_rready;
        logic        i_arready;
        logic        i_rvalid;
        logic [31:0] i_rdata;
        logic [1:0]  i_rresp;
        logic        l_arready;
        logic        l_rvalid;
        logic [31:0] l_rdata;
        logic [1:0]  l_rresp;
    } out_t;

    typedef struct packed {
        in_t  iv;
        out_t ev;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
    logic [31:0] io_master_araddr, io_master_rdata;
    logic [1:0]  io_master_rresp;

    int checks = 0;
    int passes = 0;

    out_t act;
    assign act = {io_master_arvalid, io_master_araddr, io_master_rready,
                  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
                  lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp};

    ysyx_23060184_axi_rd_arbiter dut (
        .clk               (clk),
        .rstn              (rstn),
        .ifu_arvalid       (ifu_arvalid),
        .ifu_arready       (ifu_arready),
        .ifu_araddr        (ifu_araddr),
        .ifu_rvalid        (ifu_rvalid),
        .ifu_rready        (ifu_rready),
        .ifu_rdata         (ifu_rdata),
        .ifu_rresp         (ifu_rresp),
        .lsu_arvalid       (lsu_arvalid),
        .lsu_arready       (lsu_arready),
        .lsu_araddr        (lsu_araddr),
        .lsu_rvalid        (lsu_rvalid),
        .lsu_rready        (lsu_rready),
        .lsu_rdata         (lsu_rdata),
        .lsu_rresp         (lsu_rresp),
        .io_master_arvalid (io_master_arvalid),
        .io_master_arready (io_master_arready),
        .io_master_araddr  (io_master_araddr),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rready  (io_master_rready),
        .io_master_rdata   (io_master_rdata),
        .io_master_rresp   (io_master_rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic in_t mi(input logic rs, input logic iv, input logic [31:0] ia,
                               input logic ir, input logic lv, input logic [31:0] la,
                               input logic lr, input logic mar, input logic mrv,
                               input logic [31:0] mrd, input logic [1:0] mrs);
        in_t t;
        t.rstn = rs;   t.i_arvalid = iv;  t.i_araddr = ia;  t.i_rready = ir;
        t.l_arvalid = lv; t.l_araddr = la; t.l_rready = lr;
        t.m_arready = mar; t.m_rvalid = mrv; t.m_rdata = mrd; t.m_rresp = mrs;
        return t;
    endfunction

    // Expected-output builders: everything not named is zero.
    function automatic out_t oa_i(input logic [31:0] a, input logic ar);
        out_t o = '0;
        o.m_arvalid = H; o.m_araddr = a; o.i_arready = ar;
        return o;
    endfunction

    function automatic out_t oa_l(input logic [31:0] a, input logic ar);
        out_t o = '0;
        o.m_arvalid = H; o.m_araddr = a; o.l_arready = ar;
        return o;
    endfunction

    function automatic out_t or_i(input logic rr, input logic rv, input logic [31:0] d,
                                  input logic [1:0] rs);
        out_t o = '0;
        o.m_rready = rr; o.i_rvalid = rv; o.i_rdata = d; o.i_rresp = rs;
        return o;
    endfunction

    function automatic out_t or_l(input logic rr, input logic rv, input logic [31:0] d,
                                  input logic [1:0] rs);
        out_t o = '0;
        o.m_rready = rr; o.l_rvalid = rv; o.l_rdata = d; o.l_rresp = rs;
        return o;
    endfunction

    task automatic apply(input in_t t);
        rstn = t.rstn;
        ifu_arvalid = t.i_arvalid; ifu_araddr = t.i_araddr; ifu_rready = t.i_rready;
        lsu_arvalid = t.l_arvalid; lsu_araddr = t.l_araddr; lsu_rready = t.l_rready;
        io_master_arready = t.m_arready; io_master_rvalid = t.m_rvalid;
        io_master_rdata = t.m_rdata; io_master_rresp = t.m_rresp;
    endtask

    task automatic chk_out(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%h want=%h", name, got, exp);
        else passes++;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%h want=%h", name, got, exp);
        else passes++;
    endtask

    vec_t vec[$];
    out_t z;
    in_t  t;
    int   d;
    int   hit;

    initial begin
        z = '0;
        apply(mi(L, L, ZA, L, L, ZA, L, L, L, ZA, R0));

        // Reset dominates a pending request
        vec.push_back('{mi(L, H, A0, H, L, ZA, L, L, L, ZA, R0), z});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, L, ZA, R0), z});
        // IFU only: arready after 2 ADDR cycles, data after 2 wait cycles
        vec.push_back('{mi(H, H, A0, H, L, ZA, L, L, L, ZA, R0), z});
        vec.push_back('{mi(H, H, A0, H, L, ZA, L, L, L, ZA, R0), oa_i(A0, L)});
        vec.push_back('{mi(H, H, A0, H, L, ZA, L, L, L, ZA, R0), oa_i(A0, L)});
        vec.push_back('{mi(H, H, A0, H, L, ZA, L, H, L, ZA, R0), oa_i(A0, H)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, L, ZA, R0), or_i(H, L, ZA, R0)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, L, ZA, R0), or_i(H, L, ZA, R0)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, H, 32'h0000_0413, R0),
                        or_i(H, H, 32'h0000_0413, R0)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, L, ZA, R0), z});
        // Simultaneous, last_owner=IFU: LSU first in both policies; LSU gets SLVERR
        vec.push_back('{mi(H, H, A4, H, H, A1000, H, H, L, ZA, R0), z});
        vec.push_back('{mi(H, H, A4, H, H, A1000, H, H, L, ZA, R0), oa_l(A1000, H)});
        vec.push_back('{mi(H, H, A4, H, L, ZA, H, L, H, 32'hDEAD_BEEF, R2),
                        or_l(H, H, 32'hDEAD_BEEF, R2)});
        vec.push_back('{mi(H, H, A4, H, L, ZA, H, H, L, ZA, R0), z});
        vec.push_back('{mi(H, H, A4, H, L, ZA, H, H, L, ZA, R0), oa_i(A4, H)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, H, L, H, 32'h0000_0013, R1),
                        or_i(H, H, 32'h0000_0013, R1)});
        // LSU alone so that last_owner=LSU
        vec.push_back('{mi(H, L, ZA, H, H, A2000, H, H, L, ZA, R0), z});
        vec.push_back('{mi(H, L, ZA, H, H, A2000, H, H, L, ZA, R0), oa_l(A2000, H)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, H, L, H, 32'h1111_1111, R0),
                        or_l(H, H, 32'h1111_1111, R0)});
        // Simultaneous, last_owner=LSU: round-robin picks IFU, fixed priority picks LSU
        vec.push_back('{mi(H, H, A4, H, H, A1000, H, H, L, ZA, R0), z});
        vec.push_back('{mi(H, H, A4, H, H, A1000, H, H, L, ZA, R0),
                        RR ? oa_i(A4, H) : oa_l(A1000, H)});
        vec.push_back('{mi(H, RR ? L : H, RR ? ZA : A4, H, RR ? H : L, RR ? A1000 : ZA, H,
                           L, H, 32'h2222_2222, R0),
                        RR ? or_i(H, H, 32'h2222_2222, R0) : or_l(H, H, 32'h2222_2222, R0)});
        vec.push_back('{mi(H, RR ? L : H, RR ? ZA : A4, H, RR ? H : L, RR ? A1000 : ZA, H,
                           H, L, ZA, R0), z});
        vec.push_back('{mi(H, RR ? L : H, RR ? ZA : A4, H, RR ? H : L, RR ? A1000 : ZA, H,
                           H, L, ZA, R0),
                        RR ? oa_l(A1000, H) : oa_i(A4, H)});
        vec.push_back('{mi(H, L, ZA, H, L, ZA, H, L, H, 32'h3333_3333, R0),
                        RR ? or_l(H, H, 32'h3333_3333, R0) : or_i(H, H, 32'h3333_3333, R0)});
        // Owner stalls rready for 4 cycles with rvalid high
        vec.push_back('{mi(H, H, A8, L, L, ZA, L, H, L, ZA, R0), z});
        vec.push_back('{mi(H, H, A8, L, L, ZA, L, H, L, ZA, R0), oa_i(A8, H)});
        for (int k = 0; k < 4; k++) begin
            vec.push_back('{mi(H, L, ZA, L, L, ZA, L, L, H, 32'h4444_4444, R0),
                            or_i(L, H, 32'h4444_4444, R0)});
        end
        vec.push_back('{mi(H, L, ZA, H, L, ZA, L, L, H, 32'h4444_4444, R0),
                        or_i(H, H, 32'h4444_4444, R0)});
        // Stray rvalid in IDLE is ignored
        vec.push_back('{mi(H, L, ZA, H, L, ZA, H, L, H, 32'h5555_5555, R1), z});
        // Reset asserted in RESP with rvalid high: response is dropped
        vec.push_back('{mi(H, L, ZA, L, H, A3000, H, H, L, ZA, R0), z});
        vec.push_back('{mi(H, L, ZA, L, H, A3000, H, H, L, ZA, R0), oa_l(A3000, H)});
        vec.push_back('{mi(L, L, ZA, L, L, ZA, H, L, H, 32'h6666_6666, R0), z});
        vec.push_back('{mi(H, L, ZA, L, L, ZA, H, L, H, 32'h6666_6666, R0), z});
        vec.push_back('{mi(H, L, ZA, L, L, ZA, L, L, L, ZA, R0), z});

        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            apply(vec[i].iv);
            #1;
            chk_out($sformatf("vec%0d", i), act, vec[i].ev);
        end

        // Owner withdraws arvalid in ADDR: port released, nothing issued
        @(negedge clk);
        apply(mi(H, H, 32'h8000_0ABC, H, L, ZA, H, L, L, ZA, R0));
        @(negedge clk);
        ifu_arvalid = L;
        #1;
        chk32("abandon_arvalid", {31'h0, io_master_arvalid}, 32'h0);
        chk32("abandon_araddr", io_master_araddr, 32'h8000_0ABC);
        @(negedge clk);
        lsu_arvalid = H; lsu_araddr = A3000;
        #1;
        chk32("abandon_idle", io_master_araddr, ZA);
        @(negedge clk);
        #1;
        chk32("after_abandon_lsu", io_master_araddr, A3000);
        @(negedge clk);
        apply(mi(H, L, ZA, H, L, ZA, H, L, L, ZA, R0));
        @(negedge clk);
        #1;

        // IFU read with random slave latencies, bounded waits
        @(negedge clk);
        apply(mi(H, H, 32'h8000_0100, H, L, ZA, H, L, L, ZA, R0));
        d = int'($urandom_range(1, 4));
        hit = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            io_master_arready = (c >= d) ? H : L;
            #1;
            if (ifu_arready) begin
                hit = c;
                break;
            end
        end
        chk32("ar_latency", 32'(hit), 32'(d));
        chk32("ar_addr", io_master_araddr, 32'h8000_0100);
        d = int'($urandom_range(0, 5));
        hit = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ifu_arvalid = L;
            io_master_arready = L;
            io_master_rvalid = (c >= d) ? H : L;
            io_master_rdata = (c >= d) ? 32'hCAFE_F00D : ZA;
            #1;
            if (ifu_rvalid) begin
                hit = c;
                break;
            end
        end
        chk32("r_latency", 32'(hit), 32'(d));
        chk32("r_data", ifu_rdata, 32'hCAFE_F00D);
        chk32("r_lsu_quiet", {31'h0, lsu_rvalid}, 32'h0);
        @(negedge clk);
        io_master_rvalid = L;
        io_master_rdata = ZA;
        #1;
        chk32("r_done_idle", {31'h0, ifu_rvalid}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
